// File: rtl/morse_pkg.sv
// Shared state encoding and length clamp for the Morse/on-off pattern transmitter.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_GAP  = 3'd2,
        ST_DONE = 3'd3
    } morse_state_t;

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: counts 0..UNIT_TICKS-1 while enabled and flags the terminal count.
// Wraps on its own at terminal count, so back-to-back units need no clear.
module morse_unit_timer #(
    parameter int UNIT_TICKS = 1
) (
    input  logic half_sec,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic unit_end
);

    localparam int CW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

    logic [CW-1:0] cnt;

    assign unit_end = enable && (cnt == CW'(UNIT_TICKS - 1));

    always_ff @(posedge half_sec) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= unit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_tx.sv
// Morse/on-off pattern transmitter: latches pattern/len on start, replays MSB-first, UNIT_TICKS cycles per bit.
// First bit one cycle after accept; start ignored while busy. MORSE_REPEAT_EN adds a dark GAP and endless looping.
module morse_tx
    import morse_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int UNIT_TICKS = 1,
    parameter int GAP_UNITS  = 3,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic               half_sec,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               abort,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               light,
    output logic [2:0]         state
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    morse_state_t       st;
    logic [MAX_LEN-1:0] pat_q;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   len_c;
    logic [IDX_W-1:0]   first_idx;
    logic               unit_end;
    logic               tmr_en;
    logic               tmr_clr;

    assign len_c     = LEN_W'(clamp_len(int'(len), MAX_LEN));
    assign first_idx = IDX_W'(len_c - 1'b1);

    assign tmr_en  = (st == ST_SEND) || (st == ST_GAP);
    assign tmr_clr = !tmr_en || abort;

    assign ready = (st == ST_IDLE);
    assign busy  = tmr_en;
    assign state = st;

`ifdef MORSE_REPEAT_EN
    localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

    logic [LEN_W-1:0] len_q;
    logic [GW-1:0]    gap_cnt;
    logic [IDX_W-1:0] reload_idx;

    assign reload_idx = IDX_W'(len_q - 1'b1);
`endif

    morse_unit_timer #(
        .UNIT_TICKS(UNIT_TICKS)
    ) u_timer (
        .half_sec(half_sec),
        .reset   (reset),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .unit_end(unit_end)
    );

    always_ff @(posedge half_sec) begin
        if (reset) begin
            st    <= ST_IDLE;
            light <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            pat_q <= '0;
`ifdef MORSE_REPEAT_EN
            len_q   <= '0;
            gap_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Abort wins over any terminal count, so no done can slip out.
            if (abort && (st != ST_IDLE)) begin
                st    <= ST_IDLE;
                light <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        light <= 1'b0;
                        if (start && !abort) begin
                            pat_q <= pattern;
`ifdef MORSE_REPEAT_EN
                            len_q <= len_c;
`endif
                            if (len_c == '0) begin
                                st   <= ST_DONE;
                                done <= 1'b1;
                            end else begin
                                st    <= ST_SEND;
                                idx   <= first_idx;
                                light <= pattern[first_idx];
                            end
                        end
                    end
                    ST_SEND: begin
                        if (unit_end) begin
                            if (idx != '0) begin
                                idx   <= idx - 1'b1;
                                light <= pat_q[idx - 1'b1];
                            end else begin
                                light <= 1'b0;
`ifdef MORSE_REPEAT_EN
                                st      <= ST_GAP;
                                gap_cnt <= '0;
`else
                                st   <= ST_DONE;
                                done <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef MORSE_REPEAT_EN
                    ST_GAP: begin
                        light <= 1'b0;
                        if (unit_end) begin
                            if (gap_cnt == GW'(GAP_UNITS - 1)) begin
                                st    <= ST_SEND;
                                idx   <= reload_idx;
                                light <= pat_q[reload_idx];
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                    end
`endif
                    ST_DONE: begin
                        light <= 1'b0;
                        st    <= ST_IDLE;
                    end
                    default: begin
                        light <= 1'b0;
                        st    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
